// File: rtl/i2c_master.sv
// i2c_master: single-master I2C controller. Each command runs one complete
// transaction: START, 7-bit address + R/W, one data byte, STOP. Writes send
// one byte; reads receive one byte and answer it with a NACK. Bit timing uses
// four quarter-bit phases of Q clk cycles each, matching our I2C slave.
module i2c_master #(
  parameter int SYS_FREQ = 40000000,
  parameter int I2C_FREQ = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       newd,
  input  logic       op,
  input  logic [6:0] addr,
  input  logic [7:0] din,
  output logic       scl,
  inout  wire        sda,
  output logic [7:0] dout,
  output logic       busy,
  output logic       ack_err,
  output logic       done
);

  // Quarter-bit length in clk cycles and the width of its cycle counter.
  localparam int Q  = SYS_FREQ / I2C_FREQ / 4;
  localparam int CW = (Q > 1) ? $clog2(Q) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(Q - 1);

  typedef enum logic [3:0] {
    IDLE,
    START,
    SEND_ADDR,
    ADDR_ACK,
    WRITE_DATA,
    WRITE_ACK,
    READ_DATA,
    MASTER_ACK,
    STOP
  } state_t;

  state_t          state_q,   state_d;
  logic [1:0]      phase_q,   phase_d;
  logic [CW-1:0]   cnt_q,     cnt_d;
  logic [2:0]      bit_q,     bit_d;
  logic            op_q,      op_d;
  logic [6:0]      addr_q,    addr_d;
  logic [7:0]      din_q,     din_d;
  logic [7:0]      rx_q,      rx_d;
  logic [7:0]      dout_q,    dout_d;
  logic            busy_q,    busy_d;
  logic            ack_err_q, ack_err_d;
  logic            done_q,    done_d;
  logic            scl_q,     scl_d;
  logic            sda_en_q,  sda_en_d;
  logic            sda_t_q,   sda_t_d;

  logic       lastCycle;
  logic       bitEnd;
  logic       sampleNow;
  logic       accept;
  logic       phaseChange;
  logic [7:0] addrByte;

  // A command is only taken in IDLE and never in the done cycle, so a strobe
  // that overlaps the completion pulse is dropped.
  assign accept      = (state_q == IDLE) && newd && !done_q;
  assign lastCycle   = (cnt_q == CNT_LAST);
  assign bitEnd      = lastCycle && (phase_q == 2'd3);
  assign sampleNow   = lastCycle && (phase_q == 2'd2);
  assign phaseChange = accept || ((state_q != IDLE) && lastCycle);
  assign addrByte    = {addr_q, op_q};

  // Next-state logic: bit timing, transaction sequencing and the bus levels
  // that take effect at the start of the coming quarter-bit phase.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    op_d      = op_q;
    addr_d    = addr_q;
    din_d     = din_q;
    rx_d      = rx_q;
    dout_d    = dout_q;
    busy_d    = busy_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;
    scl_d     = scl_q;
    sda_en_d  = sda_en_q;
    sda_t_d   = sda_t_q;

    if (state_q == IDLE) begin
      if (accept) begin
        op_d      = op;
        addr_d    = addr;
        din_d     = din;
        ack_err_d = 1'b0;
        busy_d    = 1'b1;
        state_d   = START;
        phase_d   = 2'd0;
        cnt_d     = '0;
        bit_d     = 3'd0;
      end
    end else begin
      if (lastCycle) begin
        cnt_d   = '0;
        phase_d = phase_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end

      case (state_q)
        START: begin
          if (bitEnd) begin
            state_d = SEND_ADDR;
            bit_d   = 3'd0;
          end
        end
        SEND_ADDR: begin
          if (bitEnd) begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = ADDR_ACK;
            end
          end
        end
        ADDR_ACK: begin
          if (sampleNow && sda) begin
            ack_err_d = 1'b1;
          end
          if (bitEnd) begin
            if (ack_err_q) begin
              state_d = STOP;
            end else if (op_q) begin
              state_d = READ_DATA;
            end else begin
              state_d = WRITE_DATA;
            end
          end
        end
        WRITE_DATA: begin
          if (bitEnd) begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = WRITE_ACK;
            end
          end
        end
        WRITE_ACK: begin
          if (sampleNow && sda) begin
            ack_err_d = 1'b1;
          end
          if (bitEnd) begin
            state_d = STOP;
          end
        end
        READ_DATA: begin
          if (sampleNow) begin
            rx_d = {rx_q[6:0], sda};
          end
          if (bitEnd) begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = MASTER_ACK;
            end
          end
        end
        MASTER_ACK: begin
          if (bitEnd) begin
            state_d = STOP;
          end
        end
        STOP: begin
          if (bitEnd) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (op_q && !ack_err_q) begin
              dout_d = rx_q;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (phaseChange) begin
      case (state_d)
        IDLE: begin
          scl_d    = 1'b1;
          sda_en_d = 1'b0;
          sda_t_d  = 1'b1;
        end
        START: begin
          scl_d    = 1'b1;
          sda_en_d = 1'b1;
          sda_t_d  = (phase_d < 2'd2);
        end
        STOP: begin
          scl_d    = (phase_d != 2'd0);
          sda_en_d = (phase_d < 2'd2);
          sda_t_d  = 1'b0;
        end
        default: begin
          scl_d = phase_d[1];
          if (phase_d == 2'd1) begin
            case (state_d)
              SEND_ADDR: begin
                sda_en_d = 1'b1;
                sda_t_d  = addrByte[3'd7 - bit_q];
              end
              WRITE_DATA: begin
                sda_en_d = 1'b1;
                sda_t_d  = din_q[3'd7 - bit_q];
              end
              MASTER_ACK: begin
                sda_en_d = 1'b1;
                sda_t_d  = 1'b1;
              end
              default: begin
                sda_en_d = 1'b0;
                sda_t_d  = 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

  // State and registered outputs; reset abandons any transaction and frees SDA.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      phase_q   <= 2'd0;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      op_q      <= 1'b0;
      addr_q    <= 7'd0;
      din_q     <= 8'd0;
      rx_q      <= 8'd0;
      dout_q    <= 8'd0;
      busy_q    <= 1'b0;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_en_q  <= 1'b0;
      sda_t_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      rx_q      <= rx_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      ack_err_q <= ack_err_d;
      done_q    <= done_d;
      scl_q     <= scl_d;
      sda_en_q  <= sda_en_d;
      sda_t_q   <= sda_t_d;
    end
  end

  assign sda     = sda_en_q ? sda_t_q : 1'bz;
  assign scl     = scl_q;
  assign dout    = dout_q;
  assign busy    = busy_q;
  assign ack_err = ack_err_q;
  assign done    = done_q;

endmodule
